exe_muldiv_seq: RTL
===================

// Module: exe_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for RV64M multiply/divide. Sits beside the EXE-stage ALU.
//  Accepts one operation per valid/ready handshake and iterates a shift-add
//  multiplier or restoring divider. Holds the result until the pipeline consumes it.
//  Decode stalls on in_ready=0; writeback takes the result on out_valid.
// PARAMETERS
//  XLEN  64  operand/result width; word (W) ops always use 32-bit halves
// PORTS
//  clk        in   1     single clock, all state on posedge
//  rst        in   1     synchronous, active-low reset (rst==0 resets)
//  flush      in   1     kill in-flight op (pipeline redirect)
//  in_valid   in   1     op request
//  in_ready   out  1     1 only in IDLE
//  op         in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  word       in   1     W variant: use src[31:0], sign-extend 32-bit result
//  src1       in   XLEN  rs1 / dividend
//  src2       in   XLEN  rs2 / divisor
//  out_valid  out  1     result valid, held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  final value; stable while out_valid
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counters=0.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//  IDLE: accept on in_valid&in_ready (cycle T). Latch op, word, operands.
//   Operands are converted to magnitudes per signedness; result sign is recorded.
//   A special divide goes to DONE at T+1; every other op goes to CALC.
//  CALC: one iteration per cycle; ITER=32 if word, else XLEN.
//   Counter counts ITER-1 down to 0; at 0 go to DONE.
//   out_valid first high at T+ITER+1 (65 cycles for 64-bit, 33 for W).
//  DONE: out_valid=1; result is fixed and sign-corrected.
//   out_valid&out_ready -> IDLE next cycle.
//   No new accept in the same cycle (in_ready=0 in DONE).
//  Multiply: unsigned magnitudes, 2*XLEN product, negated if signs differ.
//   MUL -> low XLEN bits. MULH/MULHSU/MULHU -> high XLEN bits.
//   MULHSU: src1 signed, src2 unsigned.
//   MULW -> sext(product[31:0]).
//  Divide: restoring, one quotient bit per cycle.
//   Quotient sign = sign1^sign2; remainder sign = dividend sign.
//   W ops: divide sext/zext of [31:0] per signedness, result sext 32.
//  Special divides (no iteration):
//   divisor==0 -> DIV/DIVU quotient = all ones (W: sext 32'hFFFFFFFF),
//     REM/REMU = dividend.
//   Signed overflow (min_int / -1) -> quotient = dividend, remainder = 0.
//  flush: highest priority after reset. Any state -> IDLE next cycle.
//   out_valid drops next cycle. An op presented with flush in IDLE is not accepted.
//  Reset mid-operation: same as reset; no partial result is ever presented.
//  in_valid while busy is ignored; upstream must hold it until in_ready.
//  result/out_valid change only on the IDLE/DONE transitions.
// TESTING
//  MUL 7*(-3), word=0 -> out_valid at T+65, result=64'hFFFF_FFFF_FFFF_FFEB.
//  MULHU 64'hFFFF_FFFF_FFFF_FFFF squared -> result=64'hFFFF_FFFF_FFFF_FFFE.
//  DIV -20/3 -> result=-6. REM -20/3 -> result=-2 (64'hFFFF_FFFF_FFFF_FFFE).
//  DIVU x/0 -> all ones at T+1. DIV 64'h8000_0000_0000_0000/-1 -> same value.
//   REM of that pair -> 0.
//  DIVW 32'h8000_0000/-1 -> 64'hFFFF_FFFF_8000_0000 at T+1.
//   MULW 32'h7FFF_FFFF*2 -> 64'hFFFF_FFFF_FFFF_FFFE at T+33.
//  flush at T+10 of a DIV -> IDLE at T+11, no out_valid.
//   Hold out_ready=0 for 5 cycles in DONE -> result stable, then one handshake -> IDLE.

Source files
------------

// File: rtl/exe_muldiv_seq_if.sv
// Request/response bundle between the EXE-stage issue logic and the
// multi-cycle multiply/divide sequencer.
interface exe_muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // Pipeline side: issues operations, consumes results.
  modport master (
    output flush, in_valid, op, word, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Sequencer side.
  modport slave (
    input  flush, in_valid, op, word, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/exe_muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer. One shift-add multiply or
// restoring-divide step per cycle; the finished, sign-corrected result is
// held in DONE until the writeback stage takes it.
module exe_muldiv_seq #(
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            rst,
  exe_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_hi, r_lo, r_b, r_result;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_word, r_neg_q, r_neg_r;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // ---------------- operand decode (used only on accept) ----------------
  logic            w_sgn1, w_sgn2, w_is_div, w_is_rem, w_n1, w_n2;
  logic            w_div0, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_a, w_b, w_mag1, w_mag2, w_min, w_dividend, w_spec_res;

  assign w_sgn1   = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_REM);
  assign w_sgn2   = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign w_is_div = bus.op[2];
  assign w_is_rem = bus.op[1];
  assign w_a      = bus.word ? {{(XLEN-32){w_sgn1 & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
  assign w_b      = bus.word ? {{(XLEN-32){w_sgn2 & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
  assign w_n1     = w_sgn1 & w_a[XLEN-1];
  assign w_n2     = w_sgn2 & w_b[XLEN-1];
  assign w_mag1   = w_n1 ? -w_a : w_a;
  assign w_mag2   = w_n2 ? -w_b : w_b;
  assign w_min    = bus.word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0   = w_is_div && (w_b == '0);
  assign w_ovf    = w_is_div && w_sgn1 && (w_a == w_min) && (w_b == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_dividend = bus.word ? sx32(w_a[31:0]) : w_a;
  assign w_spec_res = w_div0 ? (w_is_rem ? w_dividend : '1)
                             : (w_is_rem ? '0 : w_dividend);
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !bus.flush;

  // ---------------- one iteration step ----------------
  // Multiply: {hi,lo} shifts right; hi accumulates the multiplicand when lo[0]=1.
  logic [XLEN:0]   w_msum, w_shift;
  logic [XLEN-1:0] w_mhi, w_mlo, w_dhi, w_dlo, w_dsub, w_hi_n, w_lo_n;
  logic            w_ge;

  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mhi  = w_msum[XLEN:1];
  assign w_mlo  = {w_msum[0], r_lo[XLEN-1:1]};
  // Divide: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_dsub  = w_shift[XLEN-1:0] - r_b;
  assign w_dhi   = w_ge ? w_dsub : w_shift[XLEN-1:0];
  assign w_dlo   = {r_lo[XLEN-2:0], w_ge};
  assign w_hi_n  = r_op[2] ? w_dhi : w_mhi;
  assign w_lo_n  = r_op[2] ? w_dlo : w_mlo;

  // ---------------- final result from the last step ----------------
  // A W multiply runs 32 steps, so its 64-bit product sits 32 bits up in {hi,lo}.
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_mul_res, w_quo, w_rem, w_div_res, w_calc_res;

  assign w_prod    = r_word ? {{XLEN{1'b0}}, w_hi_n[31:0], w_lo_n[XLEN-1:32]} : {w_hi_n, w_lo_n};
  assign w_prod_s  = r_neg_q ? -w_prod : w_prod;
  assign w_mul_res = (r_op == OP_MUL)
                   ? (r_word ? sx32(w_prod_s[31:0])  : w_prod_s[XLEN-1:0])
                   : (r_word ? sx32(w_prod_s[63:32]) : w_prod_s[2*XLEN-1:XLEN]);
  assign w_quo      = r_neg_q ? -w_lo_n : w_lo_n;
  assign w_rem      = r_neg_r ? -w_hi_n : w_hi_n;
  assign w_div_res  = r_word ? sx32(r_op[1] ? w_rem[31:0] : w_quo[31:0])
                             : (r_op[1] ? w_rem : w_quo);
  assign w_calc_res = r_op[2] ? w_div_res : w_mul_res;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is just the highest-priority branch sampled on the clock edge.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.in_valid)   w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC: if (r_cnt == '0)    w_state_nxt = S_DONE;
        S_DONE: if (bus.out_ready)  w_state_nxt = S_IDLE;
        default:                    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.busy      = (r_state != S_IDLE);
    bus.result    = r_result;
  end

  // Datapath: latch operands on accept, iterate in CALC, capture the result on entry to DONE.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= bus.op;
      r_word  <= bus.word;
      r_neg_q <= w_n1 ^ w_n2;
      r_neg_r <= w_n1;
      r_hi    <= '0;
      r_b     <= w_is_div ? w_mag2 : w_mag1;
      r_lo    <= w_is_div ? (bus.word ? (w_mag1 << 32) : w_mag1) : w_mag2;
      r_cnt   <= bus.word ? CW'(31) : CW'(XLEN-1);
      if (w_special) r_result <= w_spec_res;
    end else if (r_state == S_CALC && !bus.flush) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (r_cnt == '0) r_result <= w_calc_res;
      else             r_cnt    <= r_cnt - CW'(1);
    end
  end
endmodule
